writeback_merger: RTL and testbench
===================================

# writeback_merger

Merges the two register write-back streams, the single-cycle ALU result and the load result from `sram_manager` (`enable`/`addr`/`data`/`float`), onto the integer and float register-file write ports. A load result that collides with an ALU write to the same file is held in a small in-order queue until that file's port is free. Queued writes made stale by a younger ALU write are cancelled. A per-register pending bitmap lets decode detect loads that have not yet landed.

## Interface
- `DEPTH`, 4, load-result queue entries (power of two, ≥2)
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `alu_enable`  in  1  ALU write-back valid this cycle
- `alu_addr`  in  5  destination register
- `alu_data`  in  32  value
- `alu_float`  in  1  1 = float file, 0 = integer file
- `mem_enable`  in  1  load result valid (from `sram_manager` `enable`)
- `mem_addr`  in  5  load destination (`sram_manager` `addr`)
- `mem_data`  in  32  load data (`sram_manager` `data`)
- `mem_float`  in  1  load targets float file (`sram_manager` `float`)
- `int_we`  out  1  integer-file write strobe (registered)
- `int_addr`  out  5  integer-file write address
- `int_data`  out  32  integer-file write data
- `fp_we`  out  1  float-file write strobe (registered)
- `fp_addr`  out  5  float-file write address
- `fp_data`  out  32  float-file write data
- `stall`  out  1  queue count ≥ DEPTH−1; upstream must not issue new loads
- `pending_int`  out  32  bit r set while a live queued write targets integer $r
- `pending_fp`  out  32  same for the float file
- `overflow`  out  1  sticky; a load result was dropped because the queue was full

## Operation
- Integer writes to $0 from either source are discarded: not written, not queued.
- **Per-cycle arbitration, per file F:**
  - An ALU write to F always takes F's port.
  - Otherwise F's port goes to the load candidate. The candidate is the queue head if the queue is non-empty, else the incoming `mem_*`. Only one load candidate is considered per cycle.
- **Routing the incoming load:**
  - An incoming load that does not win its port is enqueued at the tail.
  - When the queue is non-empty, an incoming load always enqueues, to preserve load order.
- **Kill rule:**
  - An ALU write to (F, r) clears the valid bit of every queued entry targeting (F, r).
  - A same-cycle `mem_*` to (F, r) is dropped and does not count as overflow. The ALU instruction is the younger one.
- **Dead entries:** an invalid (killed) head is popped without a write. This consumes that cycle's load slot.
- **Full queue:** when the queue is full and the head does not pop this cycle, an incoming load is dropped and `overflow` is set. `overflow` clears only on reset.
- **Simultaneous push and pop:** count is unchanged and both operations happen.
- **Pointers:** wrap modulo DEPTH. Count is a separate ($clog2(DEPTH)+1)-bit register.
- **Pending bitmaps:** combinational OR over valid queue entries, decoded by (float, addr). An entry written to a port this cycle is still visible in the bitmap this cycle.

## Timing
- Write ports are registered: an input accepted in cycle n produces its strobe in cycle n+1. A queued entry popped in cycle n also produces its strobe in cycle n+1.
- **Reset values:** all write strobes, addrs and data 0; `stall` 0; `pending_*` 0; `overflow` 0; queue empty with pointers at 0.
- Reset mid-operation discards all queued entries with no writes.
- Best-case load latency is 1 cycle. Worst-case is 1 + queue position + cycles of ALU occupancy on the target file.
- `stall` is derived from the registered count. It therefore reflects the state at the start of the cycle.

## Structure
- Shared package: `REG_W` = 5, `DATA_W` = 32, and the queue-entry struct {valid, float, addr[4:0], data[31:0]}.
- One sub-module, `wb_queue`: the DEPTH-entry FIFO with per-entry kill by (float, addr) match and the pending-bitmap decode.
- The arbitration and output registers live in `writeback_merger`.

## Test plan
- **Independent streams:** ALU int $3 = 7 and load fp $2 = 30 in the same cycle → next cycle `int_we` with $3 = 7 and `fp_we` with $2 = 30; queue stays empty.
- **Collision:** ALU int $4 = 1 and load int $5 = 10 in the same cycle → `int_we` $4 = 1 the next cycle and $5 = 10 the cycle after; `pending_int[5]` = 1 for exactly one cycle.
- **Kill:** load int $6 = 9 is queued behind 3 cycles of ALU int writes, and one of those ALU writes is int $6 = 5 → $6 = 5 is written and 9 is never written; `pending_int[6]` clears in the kill cycle.
- **Full queue:** hold ALU int writes every cycle and issue DEPTH+1 int loads → `stall` rises when count reaches 3; the 5th load is dropped and `overflow` = 1; after the ALU stops, the 4 kept loads drain in order, one per cycle.
- **Zero register:** load int $0 = 99 and ALU int $0 = 1 → no `int_we`, no queue entry.
- **Reset mid-drain:** assert `reset` with 2 entries queued → the following cycle all outputs are 0, no write strobes fire, and `pending_*` = 0.

Source files
------------

// File: rtl/writeback_merger_pkg.sv
// Shared widths and the queued write-back entry layout.
// Used by the write-back merger top and its load-result queue.
// No logic here.
package writeback_merger_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  // One queued load result; valid drops when a younger ALU write kills it.
  typedef struct packed {
    logic              valid;
    logic              float;
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// In-order load-result queue with per-entry kill and pending-register decode.
// Latency: pushed entry is visible at the head the cycle after the push.
// Backpressure: caller must not push when full unless it pops in the same cycle.
module wb_queue
  import writeback_merger_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  input  logic                       kill,
  input  logic                       kill_float,
  input  logic [REG_W-1:0]           kill_addr,
  output wb_entry_t                  head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic [31:0]                pending_int,
  output logic [31:0]                pending_fp
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         slots [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  assign head  = slots[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Storage and pointers: kill matching entries, retire the head, append the tail.
  // Push is applied last so a full-queue push+pop onto the same slot keeps the new entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && slots[i].float == kill_float && slots[i].addr == kill_addr)
          slots[i].valid <= 1'b0;
      end
      if (pop) begin
        slots[rd_ptr].valid <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        slots[wr_ptr] <= push_entry;
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pending bitmaps: OR of every still-valid entry, split by register file.
  always_comb begin
    pending_int = '0;
    pending_fp  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slots[i].valid) begin
        if (slots[i].float) pending_fp[slots[i].addr]  = 1'b1;
        else                pending_int[slots[i].addr] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_merger.sv
// Merges ALU and load write-backs onto the integer and float register-file ports.
// Latency: 1 cycle best case; queued loads wait behind older loads and ALU port use.
// Backpressure: stall when queue count >= DEPTH-1; loads arriving at a full queue are dropped (sticky overflow).
module writeback_merger
  import writeback_merger_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_enable,
  input  logic [REG_W-1:0]  alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_float,
  input  logic              mem_enable,
  input  logic [REG_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_float,
  output logic              int_we,
  output logic [REG_W-1:0]  int_addr,
  output logic [DATA_W-1:0] int_data,
  output logic              fp_we,
  output logic [REG_W-1:0]  fp_addr,
  output logic [DATA_W-1:0] fp_data,
  output logic              stall,
  output logic [31:0]       pending_int,
  output logic [31:0]       pending_fp,
  output logic              overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_ok, mem_live;
  logic          int_busy, fp_busy;
  logic          push, pop, drop;
  wb_entry_t     head, ld, mem_entry;
  logic [CW-1:0] count;
  logic          empty, full;

  // Integer $0 is never written; a same-cycle ALU write to the same register
  // is younger than the load, so the load is simply dropped.
  assign alu_ok   = alu_enable && (alu_float || alu_addr != '0);
  assign mem_live = mem_enable && (mem_float || mem_addr != '0) &&
                    !(alu_ok && alu_float == mem_float && alu_addr == mem_addr);
  assign int_busy = alu_ok && !alu_float;
  assign fp_busy  = alu_ok && alu_float;
  assign mem_entry = '{valid: 1'b1, float: mem_float, addr: mem_addr, data: mem_data};
  assign stall     = (count >= CW'(DEPTH - 1));

  // Load-slot arbitration: one candidate per cycle (head if any, else incoming).
  // ld.valid doubles as the load write strobe for the chosen file.
  always_comb begin
    ld   = '0;
    push = 1'b0;
    pop  = 1'b0;
    drop = 1'b0;
    if (!empty) begin
      if (!head.valid) begin
        pop = 1'b1;
      end else if (!(head.float ? fp_busy : int_busy)) begin
        pop = 1'b1;
        ld  = head;
      end
      if (mem_live) begin
        if (full && !pop) drop = 1'b1;
        else              push = 1'b1;
      end
    end else if (mem_live) begin
      if (mem_float ? fp_busy : int_busy) push = 1'b1;
      else                                ld   = mem_entry;
    end
  end

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (mem_entry),
    .pop         (pop),
    .kill        (alu_ok),
    .kill_float  (alu_float),
    .kill_addr   (alu_addr),
    .head        (head),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .pending_int (pending_int),
    .pending_fp  (pending_fp)
  );

  // Registered write ports: ALU owns a file's port when active, else the load slot; idle ports read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_we   <= 1'b0;
      int_addr <= '0;
      int_data <= '0;
      fp_we    <= 1'b0;
      fp_addr  <= '0;
      fp_data  <= '0;
      overflow <= 1'b0;
    end else begin
      int_we   <= 1'b0;
      int_addr <= '0;
      int_data <= '0;
      fp_we    <= 1'b0;
      fp_addr  <= '0;
      fp_data  <= '0;
      if (int_busy) begin
        int_we   <= 1'b1;
        int_addr <= alu_addr;
        int_data <= alu_data;
      end else if (ld.valid && !ld.float) begin
        int_we   <= 1'b1;
        int_addr <= ld.addr;
        int_data <= ld.data;
      end
      if (fp_busy) begin
        fp_we   <= 1'b1;
        fp_addr <= alu_addr;
        fp_data <= alu_data;
      end else if (ld.valid && ld.float) begin
        fp_we   <= 1'b1;
        fp_addr <= ld.addr;
        fp_data <= ld.data;
      end
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_merger.sv
// Directed bench for writeback_merger: table of single-cycle vectors plus
// hand-written multi-cycle sequences (collision, kill, full queue, reset mid-drain).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_writeback_merger;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_enable, alu_float, mem_enable, mem_float;
  logic [4:0]  alu_addr, mem_addr;
  logic [31:0] alu_data, mem_data;
  logic        int_we, fp_we, stall, overflow;
  logic [4:0]  int_addr, fp_addr;
  logic [31:0] int_data, fp_data, pending_int, pending_fp;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  writeback_merger #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_enable(alu_enable), .alu_addr(alu_addr), .alu_data(alu_data), .alu_float(alu_float),
    .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_data(mem_data), .mem_float(mem_float),
    .int_we(int_we), .int_addr(int_addr), .int_data(int_data),
    .fp_we(fp_we), .fp_addr(fp_addr), .fp_data(fp_data),
    .stall(stall), .pending_int(pending_int), .pending_fp(pending_fp), .overflow(overflow)
  );

  typedef struct packed {
    logic        ae; logic [4:0] aa; logic [31:0] ad; logic af;
    logic        me; logic [4:0] ma; logic [31:0] md; logic mf;
    logic        iwe; logic [4:0] ia; logic [31:0] id;
    logic        fwe; logic [4:0] fa; logic [31:0] fd;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic ae, input logic [4:0] aa, input logic [31:0] ad, input logic af,
                       input logic me, input logic [4:0] ma, input logic [31:0] md, input logic mf);
    alu_enable = ae; alu_addr = aa; alu_data = ad; alu_float = af;
    mem_enable = me; mem_addr = ma; mem_data = md; mem_float = mf;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_int(input string nm, input logic [4:0] a, input logic [31:0] d);
    chk({nm, " int_we"}, 32'(int_we), 32'd1);
    chk({nm, " int_addr"}, 32'(int_addr), 32'(a));
    chk({nm, " int_data"}, int_data, d);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " int_we"}, 32'(int_we), 32'd0);
    chk({nm, " int_addr"}, 32'(int_addr), 32'd0);
    chk({nm, " int_data"}, int_data, 32'd0);
    chk({nm, " fp_we"}, 32'(fp_we), 32'd0);
    chk({nm, " fp_addr"}, 32'(fp_addr), 32'd0);
    chk({nm, " fp_data"}, fp_data, 32'd0);
    chk({nm, " stall"}, 32'(stall), 32'd0);
    chk({nm, " pending_int"}, pending_int, 32'd0);
    chk({nm, " pending_fp"}, pending_fp, 32'd0);
    chk({nm, " overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    //          ae   aa  ad        af   me   ma  md      mf   iwe  ia  id      fwe  fa  fd
    vecs[0] = '{1'b1, 5'd3, 32'd7,     1'b0, 1'b1, 5'd2, 32'd30,   1'b1, 1'b1, 5'd3, 32'd7,    1'b1, 5'd2, 32'd30};
    vecs[1] = '{1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 5'd5, 32'h55,   1'b0, 1'b1, 5'd5, 32'h55,   1'b0, 5'd0, 32'd0};
    vecs[2] = '{1'b1, 5'd9, 32'h1234,  1'b1, 1'b0, 5'd0, 32'd0,    1'b0, 1'b0, 5'd0, 32'd0,    1'b1, 5'd9, 32'h1234};
    vecs[3] = '{1'b1, 5'd0, 32'd1,     1'b0, 1'b1, 5'd0, 32'd99,   1'b0, 1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 32'd0};
    vecs[4] = '{1'b1, 5'd1, 32'd1,     1'b1, 1'b1, 5'd1, 32'd2,    1'b0, 1'b1, 5'd1, 32'd2,    1'b1, 5'd1, 32'd1};
    vecs[5] = '{1'b1, 5'd0, 32'd5,     1'b0, 1'b1, 5'd7, 32'd8,    1'b0, 1'b1, 5'd7, 32'd8,    1'b0, 5'd0, 32'd0};
    vecs[6] = '{1'b1, 5'd4, 32'd11,    1'b1, 1'b1, 5'd4, 32'd22,   1'b1, 1'b0, 5'd0, 32'd0,    1'b1, 5'd4, 32'd11};
    vecs[7] = '{1'b0, 5'd0, 32'd0,     1'b0, 1'b1, 5'd0, 32'd3,    1'b1, 1'b0, 5'd0, 32'd0,    1'b1, 5'd0, 32'd3};

    // Reset state
    reset = 1'b1;
    idle();
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;

    // Table: single-cycle vectors, then an idle cycle proving nothing was queued
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].ae, vecs[i].aa, vecs[i].ad, vecs[i].af,
            vecs[i].me, vecs[i].ma, vecs[i].md, vecs[i].mf);
      step();
      chk($sformatf("vec%0d int_we", i), 32'(int_we), 32'(vecs[i].iwe));
      chk($sformatf("vec%0d fp_we", i), 32'(fp_we), 32'(vecs[i].fwe));
      if (vecs[i].iwe) begin
        chk($sformatf("vec%0d int_addr", i), 32'(int_addr), 32'(vecs[i].ia));
        chk($sformatf("vec%0d int_data", i), int_data, vecs[i].id);
      end
      if (vecs[i].fwe) begin
        chk($sformatf("vec%0d fp_addr", i), 32'(fp_addr), 32'(vecs[i].fa));
        chk($sformatf("vec%0d fp_data", i), fp_data, vecs[i].fd);
      end
      chk($sformatf("vec%0d pending_int", i), pending_int, 32'd0);
      chk($sformatf("vec%0d pending_fp", i), pending_fp, 32'd0);
      idle();
      step();
      chk($sformatf("vec%0d idle int_we", i), 32'(int_we), 32'd0);
      chk($sformatf("vec%0d idle fp_we", i), 32'(fp_we), 32'd0);
    end

    // Collision: ALU int $4 and load int $5 together
    drive(1'b1, 5'd4, 32'd1, 1'b0, 1'b1, 5'd5, 32'd10, 1'b0);
    step();
    chk_int("coll alu", 5'd4, 32'd1);
    chk("coll pending_int", pending_int, 32'h0000_0020);
    idle();
    step();
    chk_int("coll load", 5'd5, 32'd10);
    chk("coll pending_int clear", pending_int, 32'd0);
    step();
    chk("coll after int_we", 32'(int_we), 32'd0);

    // Kill: load int $6=9 queued, younger ALU int $6=5 cancels it
    drive(1'b1, 5'd1, 32'd100, 1'b0, 1'b1, 5'd6, 32'd9, 1'b0);
    step();
    chk_int("kill c0", 5'd1, 32'd100);
    chk("kill pending set", pending_int, 32'h0000_0040);
    drive(1'b1, 5'd6, 32'd5, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    chk_int("kill c1", 5'd6, 32'd5);
    chk("kill pending clear", pending_int, 32'd0);
    drive(1'b1, 5'd7, 32'd3, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    chk_int("kill c2", 5'd7, 32'd3);
    idle();
    step();
    chk("kill dead pop int_we", 32'(int_we), 32'd0);
    step();
    chk("kill drained int_we", 32'(int_we), 32'd0);

    // Full queue: ALU int every cycle, 5 int loads; 5th dropped
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd20, 32'(i), 1'b0, 1'b1, 5'(10 + i), 32'(100 + i), 1'b0);
      step();
      chk_int($sformatf("full alu%0d", i), 5'd20, 32'(i));
      chk($sformatf("full stall%0d", i), 32'(stall), (i >= 2) ? 32'd1 : 32'd0);
      chk($sformatf("full overflow%0d", i), 32'(overflow), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("full pending_int", pending_int, 32'h0000_3C00);
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      chk_int($sformatf("full drain%0d", k), 5'(10 + k), 32'(100 + k));
    end
    step();
    chk("full drained int_we", 32'(int_we), 32'd0);
    chk("full drained stall", 32'(stall), 32'd0);
    chk("full overflow sticky", 32'(overflow), 32'd1);

    // Reset mid-drain with two entries queued
    drive(1'b1, 5'd1, 32'd1, 1'b0, 1'b1, 5'd8, 32'd80, 1'b0);
    step();
    drive(1'b1, 5'd2, 32'd2, 1'b0, 1'b1, 5'd9, 32'd90, 1'b0);
    step();
    chk("rst pending before", pending_int, 32'h0000_0300);
    idle();
    reset = 1'b1;
    step();
    chk_all_zero("rst mid");
    reset = 1'b0;
    step();
    chk("rst after int_we", 32'(int_we), 32'd0);
    chk("rst after pending", pending_int, 32'd0);
    step();
    chk("rst after2 int_we", 32'(int_we), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
